// File: rtl/cmd_engine.sv
// SD CMD-line transaction engine: sends a 48-bit command with CRC7, then optionally
// receives and checks an R1/R3/R2 response, retrying failed attempts.
module cmd_engine #(
   parameter int unsigned RESP_TIMEOUT = 64,
   parameter int unsigned MAX_RETRIES  = 3,
   parameter int unsigned N_WAIT       = 8
) (
   input  logic         iclk,
   input  logic         irst_n,
   input  logic         icmd_sd,
   output logic         ocmd_sd,
   output logic         ocmd_sd_en,
   input  logic         istart,
   input  logic [5:0]   icmd_index,
   input  logic [31:0]  icmd_arg,
   input  logic [1:0]   iresp_type,
   output logic         obusy,
   output logic         odone,
   output logic [127:0] oresp,
   output logic [2:0]   ostatus,
   output logic [3:0]   oretries
);

   localparam logic [2:0] StIdle  = 3'd0;
   localparam logic [2:0] StSend  = 3'd1;
   localparam logic [2:0] StWait  = 3'd2;
   localparam logic [2:0] StRecv  = 3'd3;
   localparam logic [2:0] StCheck = 3'd4;
   localparam logic [2:0] StGap   = 3'd5;
   localparam logic [2:0] StDone  = 3'd6;

   localparam logic [7:0] TimeoutLast = 8'(RESP_TIMEOUT - 1);
   localparam logic [7:0] GapLast     = 8'(N_WAIT - 1);
   localparam logic [3:0] RetryMax    = 4'(MAX_RETRIES);

   logic [2:0]   state_q;
   logic [7:0]   cnt_q;
   logic [47:0]  frame_q;
   logic [5:0]   index_q;
   logic [1:0]   type_q;
   logic [134:0] rx_q;
   logic [6:0]   rx_crc_q;
   logic         timeout_q;

   logic         is_r2;
   logic [7:0]   last_pos;
   logic         crc_feed;
   logic         crc_err;
   logic         fmt_err;
   logic [2:0]   flags;
   logic [5:0]   bit_idx;

   function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic b);
      logic fb;
      fb = crc[6] ^ b;
      return {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
   endfunction

   function automatic logic [6:0] crc7_40(input logic [39:0] d);
      logic [6:0] c;
      c = '0;
      for (int i = 39; i >= 0; i--) c = crc7_step(c, d[i]);
      return c;
   endfunction

   assign is_r2    = (type_q == 2'd3);
   assign last_pos = is_r2 ? 8'd135 : 8'd47;
   // cnt_q is the bit position within the response (start bit = 0)
   assign crc_feed = is_r2 ? (cnt_q >= 8'd8 && cnt_q <= 8'd127) : (cnt_q <= 8'd39);

   always_comb begin
      crc_err = 1'b0;
      fmt_err = 1'b0;
      if (is_r2) begin
         crc_err = (rx_crc_q != rx_q[7:1]);
         fmt_err = rx_q[134] | (rx_q[133:128] != 6'h3f) | ~rx_q[0];
      end else begin
         crc_err = (type_q == 2'd1) && (rx_crc_q != rx_q[7:1]);
         fmt_err = rx_q[46] | (rx_q[45:40] != ((type_q == 2'd1) ? index_q : 6'h3f)) | ~rx_q[0];
      end
      flags = timeout_q ? 3'b001 : {fmt_err, crc_err, 1'b0};
   end

   always_ff @(posedge iclk) begin
      if (!irst_n) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         frame_q   <= '0;
         index_q   <= '0;
         type_q    <= '0;
         rx_q      <= '0;
         rx_crc_q  <= '0;
         timeout_q <= 1'b0;
         oresp     <= '0;
         ostatus   <= '0;
         oretries  <= '0;
      end else begin
         case (state_q)
            StIdle: begin
               if (istart) begin
                  index_q  <= icmd_index;
                  type_q   <= iresp_type;
                  frame_q  <= {2'b01, icmd_index, icmd_arg,
                               crc7_40({2'b01, icmd_index, icmd_arg}), 1'b1};
                  oresp    <= '0;
                  ostatus  <= '0;
                  oretries <= '0;
                  cnt_q    <= '0;
                  state_q  <= StSend;
               end
            end
            StSend: begin
               if (cnt_q == 8'd47) begin
                  cnt_q     <= '0;
                  timeout_q <= 1'b0;
                  state_q   <= (type_q == 2'd0) ? StDone : StWait;
               end else begin
                  cnt_q <= cnt_q + 8'd1;
               end
            end
            StWait: begin
               if (!icmd_sd) begin
                  cnt_q    <= 8'd1;
                  rx_crc_q <= '0;
                  state_q  <= StRecv;
               end else if (cnt_q == TimeoutLast) begin
                  timeout_q <= 1'b1;
                  ostatus   <= 3'b001;
                  state_q   <= StCheck;
               end else begin
                  cnt_q <= cnt_q + 8'd1;
               end
            end
            StRecv: begin
               rx_q <= {rx_q[133:0], icmd_sd};
               if (crc_feed) rx_crc_q <= crc7_step(rx_crc_q, icmd_sd);
               if (cnt_q == last_pos) state_q <= StCheck;
               else cnt_q <= cnt_q + 8'd1;
            end
            StCheck: begin
               if (!timeout_q) oresp <= is_r2 ? rx_q[127:0] : {90'd0, rx_q[45:8]};
               cnt_q <= '0;
               if (flags != 3'b000 && oretries < RetryMax) begin
                  oretries <= oretries + 4'd1;
                  ostatus  <= '0;
                  state_q  <= (N_WAIT == 0) ? StSend : StGap;
               end else begin
                  ostatus <= flags;
                  state_q <= StDone;
               end
            end
            StGap: begin
               if (cnt_q == GapLast) begin
                  cnt_q   <= '0;
                  state_q <= StSend;
               end else begin
                  cnt_q <= cnt_q + 8'd1;
               end
            end
            StDone:  state_q <= StIdle;
            default: state_q <= StIdle;
         endcase
      end
   end

   assign bit_idx    = 6'd47 - cnt_q[5:0];
   assign ocmd_sd_en = (state_q == StSend);
   assign ocmd_sd    = ocmd_sd_en ? frame_q[bit_idx] : 1'b1;
   assign obusy      = (state_q != StIdle);
   assign odone      = (state_q == StDone);

endmodule
